// File: rtl/interp_stream_pipe_if.sv
// interp_stream_pipe_if: sample-in / triple-out valid-ready bundle.
// The master side drives samples and out_ready; the slave is the interpolator.
interface interp_stream_pipe_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W = 32
);
    logic in_valid;
    logic in_ready;
    logic [DATA_W-1:0] in_sample;
    logic [1:0] in_mode;
    logic out_valid;
    logic out_ready;
    logic [ACC_W-1:0] a_value;
    logic [ACC_W-1:0] b_value;
    logic [ACC_W-1:0] c_value;

    modport master (
        output in_valid, in_sample, in_mode, out_ready,
        input in_ready, out_valid, a_value, b_value, c_value
    );

    modport slave (
        input in_valid, in_sample, in_mode, out_ready,
        output in_ready, out_valid, a_value, b_value, c_value
    );
endinterface

// File: rtl/interp_stream_pipe.sv
// interp_stream_pipe: 8-tap streaming A/B/C interpolator with a 2-stage pipe.
// Define INTERP_NORM_EN to round, shift right by 6 and clamp to sample range.
module interp_stream_pipe #(
    parameter int DATA_W = 8,
    parameter int ACC_W = 32,
    parameter int LOWER_BITS = 5
) (
    input logic clock,
    input logic reset,
    input logic flush,
    interp_stream_pipe_if.slave bus
);
    typedef logic [ACC_W-1:0] acc_t;

    // [coef set][A/B/C][tap], tap 0 = newest sample
    localparam int COEF [2][3][8] = '{
        '{'{0, 1, -5, 17, 58, -10, 4, -1},
          '{-1, 4, -11, 40, 40, -11, 4, -1},
          '{-1, 4, -10, 58, 17, -5, 1, 0}},
        '{'{0, 1, -4, 16, 64, -8, 4, -1},
          '{-1, 4, -8, 32, 32, -8, 4, -1},
          '{0, -1, 4, -8, 64, 16, -4, 1}}
    };
    localparam acc_t LO_MASK = (acc_t'(1) << LOWER_BITS) - acc_t'(1);

    function automatic acc_t apx(input acc_t a, input acc_t b);
        return ((a & ~LO_MASK) + (b & ~LO_MASK)) | ((a | b) & LO_MASK);
    endfunction

    logic [DATA_W-1:0] taps [8];
    logic [3:0] fill;
    logic l_v, s1_v, s2_v;
    logic [1:0] l_mode, s1_mode;
    acc_t prod [3][8];
    acc_t s1_prod [3][8];
    acc_t res [3];
    acc_t out_q [3];
    logic stall, accept;

    assign stall = s2_v & ~bus.out_ready;
    assign bus.in_ready = ~stall & ~flush & ~reset;
    assign accept = bus.in_valid & bus.in_ready;
    assign bus.out_valid = s2_v;
    assign bus.a_value = out_q[0];
    assign bus.b_value = out_q[1];
    assign bus.c_value = out_q[2];

    always_comb begin
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 8; k++) begin
                prod[s][k] = acc_t'(COEF[l_mode == 2'd1][s][k])
                           * acc_t'(taps[k]);
            end
        end
    end

`ifdef INTERP_NORM_EN
    localparam acc_t MAXV = acc_t'({DATA_W{1'b1}});
    logic signed [ACC_W-1:0] sh;
`endif
    acc_t ex, pos, neg, raw;

    always_comb begin
        ex = '0;
        pos = '0;
        neg = '0;
        raw = '0;
`ifdef INTERP_NORM_EN
        sh = '0;
`endif
        for (int s = 0; s < 3; s++) begin
            ex = '0;
            pos = '0;
            neg = '0;
            for (int k = 0; k < 8; k++) begin
                ex = ex + s1_prod[s][k];
                // approximate trees split products by coefficient sign
                if (COEF[0][s][k] > 0)
                    pos = apx(pos, s1_prod[s][k]);
                else if (COEF[0][s][k] < 0)
                    neg = apx(neg, acc_t'(0) - s1_prod[s][k]);
            end
            raw = (s1_mode == 2'd2) ? pos - neg : ex;
`ifdef INTERP_NORM_EN
            sh = $signed(raw + acc_t'(32)) >>> 6;
            if (sh < 0)
                res[s] = '0;
            else if (sh > $signed(MAXV))
                res[s] = MAXV;
            else
                res[s] = acc_t'(sh);
`else
            res[s] = raw;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            taps <= '{default: '0};
            fill <= '0;
            l_v <= 1'b0;
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            l_mode <= '0;
            s1_mode <= '0;
            s1_prod <= '{default: '{default: '0}};
            out_q <= '{default: '0};
        end else if (flush) begin
            fill <= '0;
            l_v <= 1'b0;
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else if (!stall) begin
            if (accept) begin
                for (int k = 7; k > 0; k--)
                    taps[k] <= taps[k-1];
                taps[0] <= bus.in_sample;
                if (fill != 4'd8)
                    fill <= fill + 4'd1;
                l_mode <= (bus.in_mode == 2'd3) ? 2'd0 : bus.in_mode;
            end
            l_v <= accept && (fill >= 4'd7);
            s1_v <= l_v;
            s1_mode <= l_mode;
            s1_prod <= prod;
            s2_v <= s1_v;
            out_q <= res;
        end
    end
endmodule

// File: tb/tb_interp_stream_pipe.sv
// tb_interp_stream_pipe: random and directed stimulus against a sample-history
// model with an in-order result scoreboard.
module tb_interp_stream_pipe;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int LB = 5;

    // spec order: tap7 .. tap0
    localparam int CL [2][3][8] = '{
        '{'{-1, 4, -10, 58, 17, -5, 1, 0},
          '{-1, 4, -11, 40, 40, -11, 4, -1},
          '{0, 1, -5, 17, 58, -10, 4, -1}},
        '{'{-1, 4, -8, 64, 16, -4, 1, 0},
          '{-1, 4, -8, 32, 32, -8, 4, -1},
          '{1, -4, 16, 64, -8, 4, -1, 0}}
    };
    localparam int BSEQ [8] = '{-1, 4, -11, 40, 40, -11, 4, -1};
    localparam int CSEQ [3] = '{-1, 4, -10};

    typedef struct {
        logic [AW-1:0] v [3];
        int age;
    } item_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int checks = 0;
    int errors = 0;
    int consumed = 0;
    int hist [8];
    int fill = 0;
    item_t q [$];
    logic [AW-1:0] obs_a [$];
    logic [AW-1:0] obs_b [$];
    logic [AW-1:0] obs_c [$];

    interp_stream_pipe_if #(.DATA_W(DW), .ACC_W(AW)) bus ();

    interp_stream_pipe #(
        .DATA_W(DW),
        .ACC_W(AW),
        .LOWER_BITS(LB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [AW-1:0] got,
                         input logic [AW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    function automatic logic [AW-1:0] apx(input logic [AW-1:0] a,
                                          input logic [AW-1:0] b);
        logic [AW-1:0] lo;
        logic [AW-1:0] hi;
        lo = (a | b) % (1 << LB);
        hi = ((a >> LB) + (b >> LB)) << LB;
        return hi + lo;
    endfunction

    function automatic logic [AW-1:0] post(input int raw);
`ifdef INTERP_NORM_EN
        int v;
        v = (raw + 32) >>> 6;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return AW'(v);
`else
        return AW'(raw);
`endif
    endfunction

    function automatic logic [AW-1:0] calc(input int m, input int s);
        int ex;
        int c;
        int p;
        logic [AW-1:0] pos;
        logic [AW-1:0] neg;
        ex = 0;
        pos = '0;
        neg = '0;
        for (int k = 0; k < 8; k++) begin
            c = CL[(m == 1) ? 1 : 0][s][7-k];
            p = c * hist[k];
            ex += p;
            if (c > 0) pos = apx(pos, AW'(p));
            if (c < 0) neg = apx(neg, AW'(-p));
        end
        if (m == 2) return post(int'(pos - neg));
        return post(ex);
    endfunction

    task automatic step();
        logic ev;
        logic er;
        logic stl;
        int m;
        item_t it;
        @(negedge clock);
        ev = (q.size() > 0) && (q[0].age >= 2);
        stl = ev && !bus.out_ready;
        er = !stl && !flush && !reset;
        check("out_valid", AW'(bus.out_valid), AW'(ev));
        check("in_ready", AW'(bus.in_ready), AW'(er));
        if (ev) begin
            check("a_value", bus.a_value, q[0].v[0]);
            check("b_value", bus.b_value, q[0].v[1]);
            check("c_value", bus.c_value, q[0].v[2]);
        end
        if (reset) begin
            q.delete();
            fill = 0;
            for (int k = 0; k < 8; k++) hist[k] = 0;
        end else if (flush) begin
            q.delete();
            fill = 0;
        end else if (!stl) begin
            if (ev) begin
                consumed++;
                obs_a.push_back(bus.a_value);
                obs_b.push_back(bus.b_value);
                obs_c.push_back(bus.c_value);
                void'(q.pop_front());
            end
            foreach (q[i]) q[i].age++;
            if (bus.in_valid) begin
                for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = int'(bus.in_sample);
                if (fill < 8) fill++;
                if (fill == 8) begin
                    m = (bus.in_mode == 2'd3) ? 0 : int'(bus.in_mode);
                    for (int s = 0; s < 3; s++) it.v[s] = calc(m, s);
                    it.age = 0;
                    q.push_back(it);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int smp, input int m);
        bus.in_valid = 1'b1;
        bus.in_sample = DW'(smp);
        bus.in_mode = 2'(m);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int base;
        int n;
        bus.in_valid = 1'b0;
        bus.in_sample = '0;
        bus.in_mode = '0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) hist[k] = 0;

        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        step();
        check("rst_a", bus.a_value, '0);
        check("rst_b", bus.b_value, '0);
        check("rst_c", bus.c_value, '0);
        reset = 1'b0;

        base = consumed;
        for (int i = 0; i < 10; i++) send(100, 0);
        idle(3);
        check("t1_count", AW'(consumed - base), AW'(3));
        check("t1_a", obs_a[$], post(6400));
        check("t1_c", obs_c[$], post(6400));

        for (int i = 0; i < 10; i++) send(100, 1);
        idle(3);
        check("t2_a", obs_a[$], post(7200));
        check("t2_b", obs_b[$], post(5400));
        check("t2_c", obs_c[$], post(7200));

        for (int i = 0; i < 8; i++) send(0, 0);
        send(1, 0);
        for (int i = 0; i < 7; i++) send(0, 0);
        idle(3);
        n = obs_b.size();
        for (int i = 0; i < 8; i++)
            check($sformatf("t3_b%0d", i), obs_b[n-8+i], post(BSEQ[i]));
        for (int i = 0; i < 3; i++)
            check($sformatf("t3_c%0d", i), obs_c[n-8+i], post(CSEQ[i]));

        for (int i = 0; i < 8; i++) send(1, 2);
        idle(3);
        check("t4_a", obs_a[$], post(48));

        bus.in_valid = 1'b1;
        for (int i = 0; i < 25; i++) begin
            bus.in_sample = DW'($urandom);
            bus.in_mode = 2'($urandom);
            bus.out_ready = !(i >= 12 && i < 17);
            step();
        end
        bus.out_ready = 1'b1;
        idle(4);
        check("t5_drain", AW'(q.size()), '0);

        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            bus.in_sample = DW'($urandom);
            step();
            n++;
        end
        check("t6_wait", AW'(bus.out_valid), AW'(1));
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.out_ready = 1'b1;
        base = consumed;
        for (int i = 0; i < 7; i++) send(int'($urandom_range(0, 255)), 0);
        idle(3);
        check("t6_warm", AW'(consumed - base), '0);
        send(int'($urandom_range(0, 255)), 0);
        idle(3);
        check("t6_first", AW'(consumed - base), AW'(1));

        for (int i = 0; i < 400; i++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_sample = DW'($urandom);
            bus.in_mode = 2'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 39) == 0);
            step();
        end
        flush = 1'b0;
        bus.out_ready = 1'b1;
        idle(6);
        check("final_drain", AW'(q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
